// File: rtl/llc_plru_engine.sv
`default_nettype none
// ============================================================================
// Module      : llc_plru_engine
// Description : Tree-PLRU replacement engine, one PLRU tree per LLC set,
//               self-initialising state array and saturating fill counter.
// Revision    : 1.0 - initial release
// ============================================================================
module llc_plru_engine #(
    parameter int ASSOCIATIVITY = 8,
    parameter int SETS_COUNT    = 2**15,
    parameter int INDEX_SIZE    = $clog2(SETS_COUNT),
    parameter int WAY_SIZE      = $clog2(ASSOCIATIVITY),
    parameter int PLRU_SIZE     = ASSOCIATIVITY - 1,
    parameter int COUNTER_SIZE  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [INDEX_SIZE-1:0]   req_index,
    input  logic [WAY_SIZE-1:0]     req_way,
    output logic                    rsp_valid,
    output logic [WAY_SIZE-1:0]     rsp_way,
    output logic                    init_done,
    output logic [COUNTER_SIZE-1:0] fill_count
);

    localparam logic [1:0] c_op_touch  = 2'b00;
    localparam logic [1:0] c_op_victim = 2'b01;
    localparam logic [1:0] c_op_fill   = 2'b10;
    localparam logic [1:0] c_op_clear  = 2'b11;

    generate
        if (ASSOCIATIVITY < 2 || (ASSOCIATIVITY & (ASSOCIATIVITY - 1)) != 0) begin : g_bad_assoc
            $error("llc_plru_engine: ASSOCIATIVITY must be a power of 2 and >= 2");
        end
        if (SETS_COUNT < 2 || (SETS_COUNT & (SETS_COUNT - 1)) != 0) begin : g_bad_sets
            $error("llc_plru_engine: SETS_COUNT must be a power of 2 and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOOKUP = 2'd2
    } state_t;

    state_t                  state_q,      state_d;
    logic [INDEX_SIZE-1:0]   sweep_q,      sweep_d;
    logic [1:0]              op_q,         op_d;
    logic [INDEX_SIZE-1:0]   index_q,      index_d;
    logic [WAY_SIZE-1:0]     way_q,        way_d;
    logic                    rsp_valid_q,  rsp_valid_d;
    logic [WAY_SIZE-1:0]     rsp_way_q,    rsp_way_d;
    logic                    init_done_q,  init_done_d;
    logic [COUNTER_SIZE-1:0] fill_count_q, fill_count_d;

    logic [PLRU_SIZE-1:0]    plru_mem [SETS_COUNT];
    logic [PLRU_SIZE-1:0]    rd_data_q;

    logic                    w_accept;
    logic                    w_mem_we;
    logic [INDEX_SIZE-1:0]   w_mem_waddr;
    logic [PLRU_SIZE-1:0]    w_mem_wdata;
    logic [WAY_SIZE-1:0]     w_victim;
    logic [WAY_SIZE-1:0]     w_touch_way;
    logic [PLRU_SIZE-1:0]    w_tree_touched;

    assign w_accept = (state_q == ST_IDLE) && req_valid;

    // Victim walk: each node bit selects the subtree holding the victim.
    always_comb begin
        int node;
        w_victim = '0;
        node     = 0;
        for (int lvl = 0; lvl < WAY_SIZE; lvl++) begin
            w_victim[WAY_SIZE-1-lvl] = rd_data_q[node];
            node = 2 * node + 1 + int'(rd_data_q[node]);
        end
    end

    assign w_touch_way = (op_q == c_op_fill) ? w_victim : way_q;

    always_comb begin
        int   node;
        logic dir;
        w_tree_touched = rd_data_q;
        node           = 0;
        dir            = 1'b0;
        for (int lvl = 0; lvl < WAY_SIZE; lvl++) begin
            dir                  = w_touch_way[WAY_SIZE-1-lvl];
            w_tree_touched[node] = ~dir;
            node                 = 2 * node + 1 + int'(dir);
        end
    end

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        op_d         = op_q;
        index_d      = index_q;
        way_d        = way_q;
        rsp_valid_d  = 1'b0;
        rsp_way_d    = rsp_way_q;
        init_done_d  = init_done_q;
        fill_count_d = fill_count_q;
        w_mem_we     = 1'b0;
        w_mem_waddr  = sweep_q;
        w_mem_wdata  = '0;
        case (state_q)
            ST_INIT: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = sweep_q;
                sweep_d     = sweep_q + 1'b1;
                if (sweep_q == INDEX_SIZE'(SETS_COUNT - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    index_d = req_index;
                    way_d   = req_way;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                w_mem_waddr = index_q;
                case (op_q)
                    c_op_touch: begin
                        w_mem_we    = 1'b1;
                        w_mem_wdata = w_tree_touched;
                        rsp_way_d   = way_q;
                    end
                    c_op_victim: begin
                        rsp_way_d = w_victim;
                    end
                    c_op_fill: begin
                        w_mem_we     = 1'b1;
                        w_mem_wdata  = w_tree_touched;
                        rsp_way_d    = w_victim;
                        fill_count_d = (&fill_count_q) ? fill_count_q : fill_count_q + 1'b1;
                    end
                    default: begin
                        w_mem_we    = 1'b1;
                        w_mem_wdata = '0;
                        rsp_way_d   = '0;
                    end
                endcase
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            sweep_q      <= '0;
            op_q         <= c_op_touch;
            index_q      <= '0;
            way_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_way_q    <= '0;
            init_done_q  <= 1'b0;
            fill_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            op_q         <= op_d;
            index_q      <= index_d;
            way_q        <= way_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_way_q    <= rsp_way_d;
            init_done_q  <= init_done_d;
            fill_count_q <= fill_count_d;
        end
    end

    // Reads and writes never share a cycle, so no bypass is needed.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            plru_mem[w_mem_waddr] <= w_mem_wdata;
        end
        if (w_accept) begin
            rd_data_q <= plru_mem[req_index];
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_way    = rsp_way_q;
    assign init_done  = init_done_q;
    assign fill_count = fill_count_q;

endmodule
`default_nettype wire
